// File: rtl/apuf_eval_sequencer_if.sv
// Controller/APUF-facing bundle for apuf_eval_sequencer.
// Latency: none (wires only).
// Backpressure: none; the sequencer ignores writes and starts while busy.
//
// Ports grouped here:
//   byte_in/byte_idx/byte_wr/start    challenge bytes and run request from the controller
//   chal_out/tig_signal               challenge and trigger towards xor_apuf
//   resp_ready/resp_bit/resp_bit_a    response handshake and bits from xor_apuf
//   busy/done/resp_maj/resp_maj_a/
//   ones_cnt/timeout_err              run status and voted results back to the controller
interface apuf_eval_sequencer_if #(
  parameter int N     = 64,
  parameter int K     = 8,
  parameter int CNT_W = 5
);
  localparam int IDX_W = (N / 8 > 1) ? $clog2(N / 8) : 1;

  logic [7:0]       byte_in;
  logic [IDX_W-1:0] byte_idx;
  logic             byte_wr;
  logic             start;
  logic [N-1:0]     chal_out;
  logic             tig_signal;
  logic             resp_ready;
  logic             resp_bit;
  logic [K-1:0]     resp_bit_a;
  logic             busy;
  logic             done;
  logic             resp_maj;
  logic [K-1:0]     resp_maj_a;
  logic [CNT_W-1:0] ones_cnt;
  logic             timeout_err;

  // Sequencer side.
  modport slave (
    input  byte_in, byte_idx, byte_wr, start, resp_ready, resp_bit, resp_bit_a,
    output chal_out, tig_signal, busy, done, resp_maj, resp_maj_a, ones_cnt, timeout_err
  );

  // Controller + APUF side (a single agent drives all sequencer inputs).
  modport master (
    output byte_in, byte_idx, byte_wr, start, resp_ready, resp_bit, resp_bit_a,
    input  chal_out, tig_signal, busy, done, resp_maj, resp_maj_a, ones_cnt, timeout_err
  );
endinterface

// File: rtl/apuf_eval_sequencer.sv
// Assembles an N-bit APUF challenge, fires the APUF NREP times and majority-votes the responses.
// Latency: NREP*(SETTLE + response wait + 1) + 1 cycles from start to the done pulse.
// Backpressure: none; byte writes and start are dropped outside IDLE, APUF pacing via resp_ready edges.
//
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high; aborts a run without a done pulse
//   bus   apuf_eval_sequencer_if.slave: controller byte writes/start in, challenge and
//         trigger out to xor_apuf, xor_apuf responses in, status and voted results out
module apuf_eval_sequencer #(
  parameter int N       = 64,
  parameter int K       = 8,
  parameter int NREP    = 15,
  parameter int CNT_W   = 5,
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  apuf_eval_sequencer_if.slave  bus
);

  localparam int NB    = N / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0] NREP_C = CNT_W'(NREP);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(NREP / 2);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    sIdle,
    sSettle,
    sWait,
    sDone
  } state_t;

  state_t           state;
  logic [N-1:0]     chalReg;
  logic             respPrev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntA [K];
  logic [CNT_W-1:0] rep;
  logic [SET_W-1:0] settleCnt;
  logic [TO_W-1:0]  waitCnt;

  logic             respEdge;
  logic [CNT_W-1:0] cntNext;
  logic [CNT_W-1:0] cntANext [K];
  logic [CNT_W-1:0] repNext;
  logic [K-1:0]     majANext;

  assign bus.chal_out = chalReg;

  // Only a fresh low->high transition counts, so a resp_ready left high from a
  // previous fire cannot be mistaken for the answer to the current one.
  assign respEdge = bus.resp_ready & ~respPrev;

  // Counts as they would be after sampling the current response; used both to
  // update the counters and to vote on the final sample in the same cycle.
  always_comb begin
    cntNext = cnt;
    if (bus.resp_bit && (cnt != NREP_C)) begin
      cntNext = cnt + 1'b1;
    end
    for (int k = 0; k < K; k++) begin
      cntANext[k] = cntA[k];
      if (bus.resp_bit_a[k] && (cntA[k] != NREP_C)) begin
        cntANext[k] = cntA[k] + 1'b1;
      end
      majANext[k] = (cntANext[k] > HALF_C);
    end
    repNext = rep;
    if (rep != NREP_C) begin
      repNext = rep + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= sIdle;
      chalReg         <= '0;
      respPrev        <= 1'b0;
      cnt             <= '0;
      rep             <= '0;
      settleCnt       <= '0;
      waitCnt         <= '0;
      for (int k = 0; k < K; k++) begin
        cntA[k] <= '0;
      end
      bus.tig_signal  <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.resp_maj    <= 1'b0;
      bus.resp_maj_a  <= '0;
      bus.ones_cnt    <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      respPrev <= bus.resp_ready;

      case (state)
        sIdle: begin
          // A write in the same cycle as start lands before the run begins,
          // since the challenge is frozen only from the next cycle on.
          if (bus.byte_wr) begin
            for (int s = 0; s < NB; s++) begin
              if (bus.byte_idx == IDX_W'(s)) begin
                chalReg[N-1-8*s -: 8] <= bus.byte_in;
              end
            end
          end
          if (bus.start) begin
            state           <= sSettle;
            cnt             <= '0;
            rep             <= '0;
            settleCnt       <= '0;
            for (int k = 0; k < K; k++) begin
              cntA[k] <= '0;
            end
            bus.timeout_err <= 1'b0;
            bus.busy        <= 1'b1;
          end
        end

        sSettle: begin
          if (settleCnt == SET_LAST) begin
            state          <= sWait;
            waitCnt        <= '0;
            bus.tig_signal <= 1'b1;
          end else begin
            settleCnt <= settleCnt + 1'b1;
          end
        end

        sWait: begin
          if (respEdge) begin
            cnt            <= cntNext;
            cntA           <= cntANext;
            rep            <= repNext;
            bus.tig_signal <= 1'b0;
            if (repNext == NREP_C) begin
              state          <= sDone;
              bus.done       <= 1'b1;
              bus.resp_maj   <= (cntNext > HALF_C);
              bus.resp_maj_a <= majANext;
              bus.ones_cnt   <= cntNext;
            end else begin
              state     <= sSettle;
              settleCnt <= '0;
            end
          end else if (waitCnt == TO_LAST) begin
            // Abort without touching the result registers: the last good
            // result stays visible alongside the error flag.
            state           <= sDone;
            bus.done        <= 1'b1;
            bus.tig_signal  <= 1'b0;
            bus.timeout_err <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end

        sDone: begin
          state    <= sIdle;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end

        default: begin
          state <= sIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apuf_eval_sequencer.sv
module tb_apuf_eval_sequencer;
  localparam int N = 64, K = 8, NREP = 15, CNT_W = 5, SETTLE = 16, TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apuf_eval_sequencer_if #(.N(N), .K(K), .CNT_W(CNT_W)) ifc ();

  apuf_eval_sequencer #(.N(N), .K(K), .NREP(NREP), .CNT_W(CNT_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT))
    dut (.clk(clk), .rst(rst), .bus(ifc));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef bit pat_t [NREP];

  // Reference state: challenge image and per-sample response patterns.
  logic [N-1:0] chalModel;
  pat_t         patBit;
  logic [K-1:0] patA [NREP];
  int           expOnes;
  logic         expMaj;
  logic [K-1:0] expMajA;

  // Observations recorded by run_eval.
  int fires, doneCnt, badLow, doneCyc, startCyc, firstTigCyc;
  logic loopExpired, busyAfterStart, toAfterStart, busyAtDone, busyAfterDone;
  logic [N-1:0] chalAtDone;
  logic snapTig, snapBusy, snapDone, snapMaj, snapTo;
  logic [K-1:0] snapMajA;
  logic [CNT_W-1:0] snapOnes;
  logic [N-1:0] snapChal;

  function automatic pat_t shuffled(input int ones);
    pat_t p;
    for (int i = 0; i < NREP; i++) p[i] = (i < ones);
    for (int i = NREP - 1; i > 0; i--) begin
      int j;
      bit t;
      j = int'($urandom_range(0, i));
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    return p;
  endfunction

  // onesA3 < 0 leaves APUF 3 random; the vote is computed by counting.
  task automatic make_pattern(input int ones, input int onesA3, input bit allA0);
    pat_t p3;
    patBit = shuffled(ones);
    p3 = shuffled(onesA3 < 0 ? 0 : onesA3);
    for (int i = 0; i < NREP; i++) begin
      patA[i] = K'($urandom);
      if (onesA3 >= 0) patA[i][3] = p3[i];
      if (allA0) patA[i][0] = 1'b1;
    end
    expOnes = 0;
    for (int i = 0; i < NREP; i++) expOnes += int'(patBit[i]);
    expMaj = (2 * expOnes > NREP);
    for (int k = 0; k < K; k++) begin
      int c;
      c = 0;
      for (int i = 0; i < NREP; i++) c += int'(patA[i][k]);
      expMajA[k] = (2 * c > NREP);
    end
  endtask

  task automatic write_byte(input int idx, input logic [7:0] val);
    @(negedge clk);
    ifc.byte_wr = 1'b1; ifc.byte_idx = 3'(idx); ifc.byte_in = val;
    chalModel[N-1-8*idx -: 8] = val;
    @(negedge clk);
    ifc.byte_wr = 1'b0;
  endtask

  // Acts as controller and APUF for one run, observing at every negedge.
  task automatic run_eval(input int d, input bit noResp, input bit midWr, input bit midStart,
                          input int abortAt, input bit wrWithStart, input logic [7:0] wrByte, input int wrIdx);
    int sIdx, hc, lowCnt, endIn;
    bit prevTig, first, rstPending, aborted;
    sIdx = 0; hc = 0; lowCnt = 0; endIn = -1;
    prevTig = 0; first = 1; rstPending = 0; aborted = 0;
    fires = 0; doneCnt = 0; badLow = 0; doneCyc = -1; firstTigCyc = -1; loopExpired = 1;
    @(negedge clk);
    ifc.start = 1'b1;
    startCyc = cyc;
    if (wrWithStart) begin
      ifc.byte_wr = 1'b1; ifc.byte_in = wrByte; ifc.byte_idx = 3'(wrIdx);
      chalModel[N-1-8*wrIdx -: 8] = wrByte;
    end
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      ifc.start = 1'b0; ifc.byte_wr = 1'b0; ifc.resp_ready = 1'b0;
      if (first) begin busyAfterStart = ifc.busy; toAfterStart = ifc.timeout_err; first = 0; end
      if (rstPending) begin
        snapTig = ifc.tig_signal; snapBusy = ifc.busy; snapDone = ifc.done; snapMaj = ifc.resp_maj;
        snapTo = ifc.timeout_err; snapMajA = ifc.resp_maj_a; snapOnes = ifc.ones_cnt; snapChal = ifc.chal_out;
        rst = 1'b0; rstPending = 0;
      end
      if (ifc.tig_signal && !prevTig) begin
        fires++;
        if (lowCnt != SETTLE) badLow++;
        hc = 0;
        if (fires == 1) firstTigCyc = cyc;
      end
      if (ifc.tig_signal) begin hc++; lowCnt = 0; end
      else if (ifc.busy) lowCnt++;
      prevTig = ifc.tig_signal;
      if (ifc.done) begin
        doneCnt++; doneCyc = cyc; busyAtDone = ifc.busy; chalAtDone = ifc.chal_out;
        if (endIn < 0) endIn = 2;
      end
      if (ifc.tig_signal) begin
        if (!noResp && hc == d && sIdx < NREP) begin
          ifc.resp_ready = 1'b1; ifc.resp_bit = patBit[sIdx]; ifc.resp_bit_a = patA[sIdx]; sIdx++;
        end
        if (midWr && fires == 2 && hc == 1) begin
          ifc.byte_wr = 1'b1; ifc.byte_idx = 3'd0; ifc.byte_in = ~chalModel[N-1 -: 8];
        end
        if (midStart && fires == 3 && hc == 2) ifc.start = 1'b1;
        if (abortAt != 0 && fires == abortAt && hc == 2 && !aborted) begin
          rst = 1'b1; rstPending = 1; aborted = 1; endIn = 300;
        end
      end
      if (endIn == 0) begin loopExpired = 0; break; end
      if (endIn > 0) endIn--;
    end
    busyAfterDone = ifc.busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ifc.chal_out !== '0) begin bad++; $display("FAIL reset chal_out got=%h want=0", ifc.chal_out); end
    total++; if (ifc.tig_signal !== 1'b0) begin bad++; $display("FAIL reset tig got=%b want=0", ifc.tig_signal); end
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", ifc.busy); end
    total++; if (ifc.done !== 1'b0) begin bad++; $display("FAIL reset done got=%b want=0", ifc.done); end
    total++; if (ifc.resp_maj !== 1'b0) begin bad++; $display("FAIL reset resp_maj got=%b want=0", ifc.resp_maj); end
    total++; if (ifc.resp_maj_a !== '0) begin bad++; $display("FAIL reset resp_maj_a got=%h want=0", ifc.resp_maj_a); end
    total++; if (ifc.ones_cnt !== '0) begin bad++; $display("FAIL reset ones_cnt got=%0d want=0", ifc.ones_cnt); end
    total++; if (ifc.timeout_err !== 1'b0) begin bad++; $display("FAIL reset timeout_err got=%b want=0", ifc.timeout_err); end
    rst = 1'b0;
    chalModel = '0;
  endtask

  task automatic test_byte_write();
    logic [7:0] fixedBytes [8];
    fixedBytes = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    for (int i = 0; i < 6; i++) begin
      write_byte(int'($urandom_range(0, 7)), 8'($urandom));
      total++; if (ifc.chal_out !== chalModel) begin bad++; $display("FAIL rand_write chal got=%h want=%h", ifc.chal_out, chalModel); end
    end
    for (int i = 0; i < 8; i++) write_byte(i, fixedBytes[i]);
    total++; if (ifc.chal_out !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL fixed_write chal got=%h want=0123456789abcdef", ifc.chal_out); end
    total++; if (ifc.tig_signal !== 1'b0) begin bad++; $display("FAIL write tig got=%b want=0", ifc.tig_signal); end
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL write busy got=%b want=0", ifc.busy); end
  endtask

  task automatic check_results(input string tag);
    total++; if (loopExpired !== 1'b0) begin bad++; $display("FAIL %s no done within budget", tag); end
    total++; if (doneCnt != 1) begin bad++; $display("FAIL %s done_count got=%0d want=1", tag, doneCnt); end
    total++; if (int'(ifc.ones_cnt) != expOnes) begin bad++; $display("FAIL %s ones_cnt got=%0d want=%0d", tag, ifc.ones_cnt, expOnes); end
    total++; if (ifc.resp_maj !== expMaj) begin bad++; $display("FAIL %s resp_maj got=%b want=%b", tag, ifc.resp_maj, expMaj); end
    total++; if (ifc.resp_maj_a !== expMajA) begin bad++; $display("FAIL %s resp_maj_a got=%h want=%h", tag, ifc.resp_maj_a, expMajA); end
  endtask

  task automatic test_normal_run();
    make_pattern(9, 7, 1'b1);
    run_eval(5, 0, 0, 0, 0, 0, 8'h00, 0);
    check_results("normal");
    total++; if (fires != NREP) begin bad++; $display("FAIL normal fires got=%0d want=%0d", fires, NREP); end
    total++; if (badLow != 0) begin bad++; $display("FAIL normal settle_low_runs got=%0d wrong want=0", badLow); end
    // Each repetition: SETTLE low cycles plus 5 trigger-high cycles (last one samples).
    total++; if (doneCyc - startCyc != NREP * (SETTLE + 5) + 1) begin bad++; $display("FAIL normal latency got=%0d want=%0d", doneCyc - startCyc, NREP * (SETTLE + 5) + 1); end
    total++; if (busyAfterStart !== 1'b1) begin bad++; $display("FAIL normal busy_after_start got=%b want=1", busyAfterStart); end
    total++; if (busyAtDone !== 1'b1) begin bad++; $display("FAIL normal busy_at_done got=%b want=1", busyAtDone); end
    total++; if (busyAfterDone !== 1'b0) begin bad++; $display("FAIL normal busy_after_done got=%b want=0", busyAfterDone); end
    total++; if (ifc.ones_cnt !== 5'd9) begin bad++; $display("FAIL normal ones9 got=%0d want=9", ifc.ones_cnt); end
    total++; if (ifc.resp_maj_a[3] !== 1'b0) begin bad++; $display("FAIL normal maj_a3 got=%b want=0", ifc.resp_maj_a[3]); end
    total++; if (ifc.resp_maj_a[0] !== 1'b1) begin bad++; $display("FAIL normal maj_a0 got=%b want=1", ifc.resp_maj_a[0]); end
    total++; if (ifc.timeout_err !== 1'b0) begin bad++; $display("FAIL normal timeout_err got=%b want=0", ifc.timeout_err); end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 3; r++) begin
      make_pattern(int'($urandom_range(0, NREP)), -1, 1'b0);
      run_eval(int'($urandom_range(1, 8)), 0, 0, 0, 0, 0, 8'h00, 0);
      check_results("random");
      total++; if (fires != NREP) begin bad++; $display("FAIL random fires got=%0d want=%0d", fires, NREP); end
    end
  endtask

  task automatic test_timeout();
    int pOnes;
    logic pMaj;
    logic [K-1:0] pMajA;
    pOnes = expOnes; pMaj = expMaj; pMajA = expMajA;
    run_eval(5, 1, 0, 0, 0, 0, 8'h00, 0);
    total++; if (doneCnt != 1) begin bad++; $display("FAIL timeout done_count got=%0d want=1", doneCnt); end
    total++; if (doneCyc - firstTigCyc != TIMEOUT) begin bad++; $display("FAIL timeout delay got=%0d want=%0d", doneCyc - firstTigCyc, TIMEOUT); end
    total++; if (ifc.timeout_err !== 1'b1) begin bad++; $display("FAIL timeout flag got=%b want=1", ifc.timeout_err); end
    total++; if (int'(ifc.ones_cnt) != pOnes) begin bad++; $display("FAIL timeout held ones got=%0d want=%0d", ifc.ones_cnt, pOnes); end
    total++; if (ifc.resp_maj !== pMaj) begin bad++; $display("FAIL timeout held maj got=%b want=%b", ifc.resp_maj, pMaj); end
    total++; if (ifc.resp_maj_a !== pMajA) begin bad++; $display("FAIL timeout held maj_a got=%h want=%h", ifc.resp_maj_a, pMajA); end
    total++; if (ifc.tig_signal !== 1'b0) begin bad++; $display("FAIL timeout tig got=%b want=0", ifc.tig_signal); end
    make_pattern(int'($urandom_range(0, NREP)), -1, 1'b0);
    run_eval(3, 0, 0, 0, 0, 0, 8'h00, 0);
    total++; if (toAfterStart !== 1'b0) begin bad++; $display("FAIL timeout clear_on_start got=%b want=0", toAfterStart); end
    check_results("after_timeout");
  endtask

  task automatic test_during_run();
    make_pattern(int'($urandom_range(0, NREP)), -1, 1'b1);
    run_eval(4, 0, 1, 1, 0, 0, 8'h00, 0);
    check_results("during_run");
    total++; if (chalAtDone !== chalModel) begin bad++; $display("FAIL during_run chal got=%h want=%h", chalAtDone, chalModel); end
    total++; if (busyAfterDone !== 1'b0) begin bad++; $display("FAIL during_run busy_after got=%b want=0", busyAfterDone); end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      make_pattern(int'($urandom_range(0, NREP)), -1, 1'b0);
      run_eval(2, 0, 0, 0, 0, 1, 8'($urandom), 7 - r);
      check_results("back_to_back");
      total++; if (chalAtDone !== chalModel) begin bad++; $display("FAIL b2b chal got=%h want=%h", chalAtDone, chalModel); end
    end
  endtask

  task automatic test_reset_mid();
    make_pattern(int'($urandom_range(0, NREP)), -1, 1'b0);
    run_eval(5, 0, 0, 0, 4, 0, 8'h00, 0);
    total++; if (fires != 4) begin bad++; $display("FAIL rst_mid fires got=%0d want=4", fires); end
    total++; if (doneCnt != 0) begin bad++; $display("FAIL rst_mid done_count got=%0d want=0", doneCnt); end
    total++; if (snapTig !== 1'b0) begin bad++; $display("FAIL rst_mid tig got=%b want=0", snapTig); end
    total++; if (snapBusy !== 1'b0) begin bad++; $display("FAIL rst_mid busy got=%b want=0", snapBusy); end
    total++; if (snapDone !== 1'b0) begin bad++; $display("FAIL rst_mid done got=%b want=0", snapDone); end
    total++; if (snapOnes !== '0 || snapMaj !== 1'b0 || snapMajA !== '0 || snapTo !== 1'b0) begin
      bad++; $display("FAIL rst_mid results got=%0d/%b/%h/%b want=0/0/0/0", snapOnes, snapMaj, snapMajA, snapTo);
    end
    total++; if (snapChal !== '0) begin bad++; $display("FAIL rst_mid chal got=%h want=0", snapChal); end
    chalModel = '0;
    make_pattern(int'($urandom_range(0, NREP)), 7, 1'b1);
    run_eval(5, 0, 0, 0, 0, 0, 8'h00, 0);
    check_results("after_rst");
    total++; if (fires != NREP) begin bad++; $display("FAIL after_rst fires got=%0d want=%0d", fires, NREP); end
  endtask

  initial begin
    ifc.byte_in = '0; ifc.byte_idx = '0; ifc.byte_wr = 1'b0; ifc.start = 1'b0;
    ifc.resp_ready = 1'b0; ifc.resp_bit = 1'b0; ifc.resp_bit_a = '0;
    chalModel = '0;
    test_reset();
    test_byte_write();
    test_normal_run();
    test_random_runs();
    test_timeout();
    test_during_run();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
